// File: rtl/mem_ctrl_if.sv
// Request/response and memory bus bundle for mem_ctrl.
//   req_*  : requester -> controller request handshake (valid/ready)
//   rsp_*  : controller -> requester response handshake (valid/ready)
//   mem_*  : controller <-> single-port memory with one-cycle read latency
// Modports:
//   slave  : the controller side (accepts requests, drives the memory)
//   master : the requester/memory side (test environment or system)
interface mem_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_write, mem_wdata, mem_read
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_write, mem_wdata, mem_read
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-outstanding memory controller with a read-only upper region.
// Requests are accepted one at a time, issued to a memory with one-cycle
// read latency, and answered through a response handshake. Writes to the
// ROM half (address MSB = 1) are rejected, flagged and counted.
// Ports:
//   clk     : clock, rising-edge
//   rst     : asynchronous active-high reset
//   bus     : mem_ctrl_if.slave (request, response and memory signals)
//   err_cnt : saturating count of rejected ROM writes
module mem_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 10,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_ctrl_if.slave           bus,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RSP} state_t;

  state_t              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [ERRCNT_W-1:0] cnt_q;
  logic [ERRCNT_W-1:0] cnt_d;
  logic                rom_sel;

  assign rom_sel = addr_q[ADDR_W-1];

  // Saturating increment: stays at all-ones once reached.
  assign cnt_d = (cnt_q == {ERRCNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!we_q) begin
            err_q   <= 1'b0;
            state_q <= CAPTURE;
          end else begin
            // Write response carries no data; ROM writes are flagged.
            rdata_q <= '0;
            err_q   <= rom_sel;
            if (rom_sel) begin
              cnt_q <= cnt_d;
            end
            state_q <= RSP;
          end
        end
        CAPTURE: begin
          rdata_q <= bus.mem_rdata;
          state_q <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags and strobes come from registered state only.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.mem_read  = (state_q == ISSUE) && !we_q;
  assign bus.mem_write = (state_q == ISSUE) && we_q && !rom_sel;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign err_cnt       = cnt_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 10;
  localparam int ERRCNT_W = 8;

  logic clk;
  logic rst;
  logic [ERRCNT_W-1:0] err_cnt;

  mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERRCNT_W(ERRCNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, one-cycle registered read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
  end

  int total;
  int passed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                lat;
    int                wpulse;
    logic [DATA_W-1:0] rd;
    logic              err;
    logic [7:0]        cnt;
  } vec_t;

  vec_t vecs [7];

  // Called at a negedge. Handshakes, measures edges to rsp_valid, counts
  // mem_write cycles, consumes the response.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, output int lat,
                        output int wpulse, output logic [DATA_W-1:0] rd,
                        output logic er);
    int t;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    t = 0;
    while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("req_timeout", 1, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    wpulse = 0;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.mem_write) wpulse++;
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, wp, exp_cnt, t, hs_cnt, cyc;
    int hs_cyc [2];
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] rsps [$];
    logic er;
    total = 0;
    passed = 0;

    mem[14'h0001] = 10'h0A1;
    mem[14'h0002] = 10'h0B2;
    mem[14'h2000] = 10'h155;
    mem[14'h2003] = 10'h0C3;

    vecs[0] = '{1'b1, 14'h0005, 10'h2AB, 2, 1, 10'h000, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 14'h0005, 10'h000, 3, 0, 10'h2AB, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 14'h2003, 10'h111, 2, 0, 10'h000, 1'b1, 8'd1};
    vecs[3] = '{1'b0, 14'h2003, 10'h000, 3, 0, 10'h0C3, 1'b0, 8'd1};
    vecs[4] = '{1'b1, 14'h1FFF, 10'h3FF, 2, 1, 10'h000, 1'b0, 8'd1};
    vecs[5] = '{1'b0, 14'h1FFF, 10'h000, 3, 0, 10'h3FF, 1'b0, 8'd1};
    vecs[6] = '{1'b0, 14'h2000, 10'h000, 3, 0, 10'h155, 1'b0, 8'd1};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_rsp_err",   32'(bus.rsp_err), 0);
    check("rst_err_cnt",   32'(err_cnt), 0);
    check("rst_mem_addr",  32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_strobes",   32'({bus.mem_read, bus.mem_write}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven transactions.
    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, wp, rd, er);
      $display("vec %0d we=%0b addr=0x%04h lat=%0d wpulse=%0d rdata=0x%03h err=%0b cnt=%0d",
               i, vecs[i].we, vecs[i].addr, lat, wp, rd, er, err_cnt);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_wpulse", i),  32'(wp), 32'(vecs[i].wpulse));
      check($sformatf("v%0d_rdata", i),   32'(rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_err", i),     32'(er), 32'(vecs[i].err));
      check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d_idle", i),    32'(bus.req_ready), 1);
    end

    // Response back-pressure on a ROM read.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'h2000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    t = 0;
    while (!bus.rsp_valid && t < 20) begin @(negedge clk); t++; end
    check("bp_rsp_seen", 32'(bus.rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      $display("bp cycle %0d valid=%0b rdata=0x%03h err=%0b ready=%0b",
               c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
      check($sformatf("bp_hold_%0d", c),
            32'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready}),
            32'({1'b1, 10'h155, 1'b0, 1'b0}));
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_idle_after", 32'({bus.req_ready, bus.rsp_valid}), 32'(2'b10));

    // Error counter saturation.
    exp_cnt = 1;
    for (int i = 0; i < 260; i++) begin
      do_req(1'b1, 14'h2000 | 14'(i), 10'(i), lat, wp, rd, er);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      if (i == 253 || i >= 258)
        check($sformatf("sat_cnt_%0d", i), 32'(err_cnt), 32'(exp_cnt));
    end
    $display("saturation err_cnt=%0d", err_cnt);
    check("sat_final", 32'(err_cnt), 255);

    // Reset in CAPTURE.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'h0005;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs",
          32'({bus.rsp_valid, bus.rsp_err, bus.mem_read, bus.mem_write}), 0);
    check("mid_rst_data", 32'({bus.rsp_rdata, bus.mem_wdata}), 0);
    check("mid_rst_addr", 32'(bus.mem_addr), 0);
    check("mid_rst_cnt",  32'(err_cnt), 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("mid_rst_valid_%0d", c), 32'(bus.rsp_valid), 0);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'h0005;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("post_rst_accept", 32'({bus.req_ready, bus.mem_read}), 32'(2'b01));
    t = 0;
    while (!bus.rsp_valid && t < 20) begin @(negedge clk); t++; end
    $display("post-reset read rdata=0x%03h", bus.rsp_rdata);
    check("post_rst_rdata", 32'(bus.rsp_rdata), 32'h2AB);
    bus.rsp_ready = 1'b1;
    @(negedge clk);

    // Back-to-back reads with req_valid and rsp_ready held high.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'h0001;
    hs_cnt = 0;
    cyc = 0;
    while (rsps.size() < 2 && cyc < 40) begin
      if (bus.rsp_valid) rsps.push_back(bus.rsp_rdata);
      if (hs_cnt == 1) bus.req_addr = 14'h0002;
      if (hs_cnt == 2) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
        hs_cyc[hs_cnt] = cyc;
        hs_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("b2b_handshakes", 32'(hs_cnt), 2);
    check("b2b_responses", 32'(rsps.size()), 2);
    if (hs_cnt == 2) begin
      $display("b2b handshakes at cycles %0d and %0d", hs_cyc[0], hs_cyc[1]);
      check("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 4);
    end
    if (rsps.size() == 2) begin
      $display("b2b responses 0x%03h 0x%03h", rsps[0], rsps[1]);
      check("b2b_rsp0", 32'(rsps[0]), 32'h0A1);
      check("b2b_rsp1", 32'(rsps[1]), 32'h0B2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 14, as the request/memory address width.
REQ-002 The block SHALL expose parameter DATA_W, default 10, as the data word width.
REQ-003 The block SHALL expose parameter ERRCNT_W, default 8, as the width of the error counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, named as follows.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  1  requester presents a request.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  request address; bit ADDR_W-1 = 1 selects ROM, 0 selects RAM.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  requester consumes the response.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for write responses.
REQ-015 rsp_err  output  1  response flags a rejected ROM write.
REQ-016 err_cnt  output  ERRCNT_W  count of rejected ROM writes.
REQ-017 mem_addr  output  ADDR_W  address to the memory.
REQ-018 mem_write  output  1  memory write strobe.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_read  output  1  memory read strobe.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid one cycle after the cycle mem_read is high.

Function
REQ-022 The block SHALL implement the FSM states IDLE, ISSUE, CAPTURE and RSP.
REQ-023 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid=1 and req_ready=1 at a rising edge.
REQ-024 On a handshake, the block SHALL latch req_we, req_addr and req_wdata and go to ISSUE.
REQ-025 In ISSUE, mem_read SHALL be 1 for a read, mem_write SHALL be 1 for a write with addr[ADDR_W-1]=0, and both strobes SHALL be 0 in every other state and case.
REQ-026 The strobes SHALL be decoded only from registered state, so they carry no combinational path from req_*.
REQ-027 mem_addr and mem_wdata SHALL reflect the latched values and SHALL hold them until the next handshake.
REQ-028 ISSUE SHALL go to CAPTURE for a read and to RSP for a write.
REQ-029 CAPTURE SHALL register mem_rdata into rsp_rdata and go to RSP.
REQ-030 On a write with addr[ADDR_W-1]=1, the block SHALL suppress mem_write, enter RSP with rsp_err=1, and increment err_cnt, saturating at all-ones.
REQ-031 In RSP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until rsp_valid=1 and rsp_ready=1 at an edge, after which the block returns to IDLE.
REQ-032 rsp_err SHALL be 0 for reads and RAM writes, and rsp_rdata SHALL be 0 for all write responses.
REQ-033 Latency from handshake edge to rsp_valid high SHALL be 3 edges for reads and 2 edges for writes; the minimum request spacing is 4 cycles for reads and 3 cycles for writes.
REQ-034 req_valid asserted outside IDLE SHALL be ignored; the requester holds it until req_ready.
REQ-035 rsp_ready asserted outside RSP SHALL have no effect.
REQ-036 A ROM read (addr[ADDR_W-1]=1, req_we=0) SHALL proceed as a normal read.

Reset
REQ-037 While rst=1, the block SHALL hold state IDLE, drive every output register to 0 (rsp_valid, rsp_rdata, rsp_err, err_cnt, mem_addr, mem_wdata) and keep mem_read and mem_write at 0.
REQ-038 rst asserted mid-transaction SHALL abort the transaction immediately, with no strobe or response emitted, and req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-039 The bench SHALL check a RAM write then read: write addr 0x0005 data 0x2AB, then read 0x0005 -> mem_write=1 for exactly 1 cycle, write rsp_rdata=0 and rsp_err=0, then read rsp_rdata=0x2AB with rsp_valid 3 edges after acceptance.
REQ-040 The bench SHALL check a ROM write rejection: write addr 0x2003 -> mem_write stays 0, rsp_err=1, err_cnt goes 0 -> 1.
REQ-041 The bench SHALL check response back-pressure: hold rsp_ready=0 for 5 cycles after a read of 0x2000 -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout; IDLE follows the cycle after rsp_ready=1.
REQ-042 The bench SHALL check error-counter saturation: 260 ROM writes -> err_cnt=255 and stays at 255.
REQ-043 The bench SHALL check reset mid-operation: assert rst in CAPTURE -> rsp_valid stays 0, all outputs read 0, and a new request is accepted on the first edge after release.
REQ-044 The bench SHALL check back-to-back reads: req_valid held high continuously with addresses 0x0001 and 0x0002 -> handshakes occur 4 cycles apart and the responses return in order.
